// File: rtl/modulo_controle_partida.sv
// Game-flow controller for a battleship-style board: button edge detection,
// map load, shot validation and evaluation, timed result display and end-of-game flags.
module modulo_controle_partida #(
  parameter int MAX_SHOTS   = 20,
  parameter int SHOW_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       button_confirmation,
  input  logic [1:0] hh2,
  input  logic [2:0] at_line,
  input  logic [2:0] at_col,
  input  logic       ship_bit,
  input  logic       attacked_bit,
  input  logic [4:0] target_hits,
  output logic [1:0] status,
  output logic       po_load,
  output logic       at_clr,
  output logic       at_write,
  output logic [2:0] addr_line,
  output logic [2:0] addr_col,
  output logic [1:0] map_sel,
  output logic [1:0] rgb_output,
  output logic [4:0] hits,
  output logic [5:0] shots,
  output logic       game_over,
  output logic       win,
  output logic       coord_err
);

  // state    | meaning
  // IDLE     | waiting for a press to start
  // POSITION | waiting for a press to load the selected map
  // ATTACK   | waiting for a confirmed attack coordinate
  // EVAL     | one cycle: attack cell written, ship bit read at latched address
  // SHOW     | result held on rgb_output, then end-of-game checks
  // END      | game finished; press returns to IDLE
  typedef enum logic [2:0] {
    S_IDLE, S_POSITION, S_ATTACK, S_EVAL, S_SHOW, S_END
  } state_t;

  localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CW-1:0] SHOW_LOAD  = CW'(SHOW_CYCLES - 1);
  localparam logic [5:0]    SHOT_LIMIT = 6'(MAX_SHOTS);

  state_t        state;
  logic          btn_q;
  logic          press;
  logic [CW-1:0] show_cnt;

  assign press = button_confirmation & ~btn_q;

  always_comb begin
    status = 2'b00;
    case (state)
      S_IDLE:                   status = 2'b00;
      S_POSITION:               status = 2'b01;
      S_ATTACK, S_EVAL, S_SHOW: status = 2'b10;
      S_END:                    status = 2'b11;
      default:                  status = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= S_IDLE;
      btn_q      <= 1'b0;
      show_cnt   <= '0;
      po_load    <= 1'b0;
      at_clr     <= 1'b0;
      at_write   <= 1'b0;
      coord_err  <= 1'b0;
      addr_line  <= 3'd0;
      addr_col   <= 3'd0;
      map_sel    <= 2'b00;
      rgb_output <= 2'b00;
      hits       <= 5'd0;
      shots      <= 6'd0;
      game_over  <= 1'b0;
      win        <= 1'b0;
    end else begin
      btn_q     <= button_confirmation;
      po_load   <= 1'b0;
      at_clr    <= 1'b0;
      at_write  <= 1'b0;
      coord_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press) state <= S_POSITION;
        end
        S_POSITION: begin
          if (press) begin
            map_sel <= hh2;
            po_load <= 1'b1;
            at_clr  <= 1'b1;
            hits    <= 5'd0;
            shots   <= 6'd0;
            state   <= S_ATTACK;
          end
        end
        S_ATTACK: begin
          if (press) begin
            if (at_line > 3'd6 || at_col > 3'd4) begin
              coord_err <= 1'b1;
            end else if (attacked_bit) begin
              rgb_output <= 2'b11;
              show_cnt   <= SHOW_LOAD;
              state      <= S_SHOW;
            end else begin
              addr_line <= at_line;
              addr_col  <= at_col;
              at_write  <= 1'b1;
              state     <= S_EVAL;
            end
          end
        end
        S_EVAL: begin
          if (shots != 6'd63) shots <= shots + 6'd1;
          if (ship_bit) begin
            if (hits != 5'd31) hits <= hits + 5'd1;
            rgb_output <= 2'b01;
          end else begin
            rgb_output <= 2'b10;
          end
          show_cnt <= SHOW_LOAD;
          state    <= S_SHOW;
        end
        S_SHOW: begin
          if (show_cnt != '0) begin
            show_cnt <= show_cnt - CW'(1);
          end else begin
            rgb_output <= 2'b00;
            // a win outranks running out of shots on the same shot
            if (hits == target_hits) begin
              win       <= 1'b1;
              game_over <= 1'b1;
              state     <= S_END;
            end else if (shots == SHOT_LIMIT) begin
              win       <= 1'b0;
              game_over <= 1'b1;
              state     <= S_END;
            end else begin
              state <= S_ATTACK;
            end
          end
        end
        S_END: begin
          if (press) begin
            game_over <= 1'b0;
            win       <= 1'b0;
            hits      <= 5'd0;
            shots     <= 6'd0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
